// File: rtl/pattern_detector_pkg.sv
// Shared constants for the serial pattern detector and its match counter.
// Overlapping detection is selected at build time with PATTERN_DETECT_OVERLAP_EN.
package pattern_detector_pkg;

    localparam int          N_DEF       = 4;
    localparam logic [15:0] PATTERN_DEF = 16'h000D;
    localparam int          CNT_W_DEF   = 8;
    localparam int          FILL_W_DEF  = $clog2(N_DEF + 1);

    // Width needed to hold a fill count of 0..n inclusive.
    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] Q_MAX = {W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != Q_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial-bit sequence detector: registered one-cycle match pulse plus saturating match count.
// Build macro PATTERN_DETECT_OVERLAP_EN enables overlapping matches (default: non-overlapping).
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int             N       = N_DEF,
    parameter logic [N-1:0]   PATTERN = N'(PATTERN_DEF),
    parameter int             CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      serial_in,
    input  logic                      clr,
    output logic                      w,
    output logic [CNT_W-1:0]          match_cnt,
    output logic [$clog2(N+1)-1:0]    fill
);

    localparam int FW = fill_w(N);
    localparam logic [FW-1:0] FULL = FW'(N);

`ifdef PATTERN_DETECT_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic [N-1:0]  sr;
    logic [N-1:0]  sr_nxt;
    logic [FW-1:0] fill_inc;
    logic [FW-1:0] fill_nxt;
    logic          hit;

    always_comb begin
        sr_nxt   = sr;
        fill_inc = fill;
        fill_nxt = '0;
        hit      = 1'b0;
        if (en) begin
            sr_nxt   = {sr[N-2:0], serial_in};
            fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
            hit      = (fill_inc == FULL) && (sr_nxt == PATTERN);
            // Non-overlapping mode restarts the window so the next N bits are all fresh.
            fill_nxt = (hit && !OVERLAP) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr   <= '0;
            fill <= '0;
            w    <= 1'b0;
        end else begin
            sr   <= sr_nxt;
            fill <= fill_nxt;
            w    <= hit;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (clr),
        .q   (match_cnt)
    );

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Serial-bit sequence detector that sits directly upstream of the counter/countdown controller. It samples a one-bit stream while enabled and compares the last `N` bits against a fixed pattern. On a match it issues a one-cycle registered pulse, which the controller consumes as its detect input. It also keeps a saturating count of matches for status readback.

## Interface
- `N`, 4, pattern length in bits (2..16)
- `PATTERN`, 4'b1101, pattern to detect; bit `N-1` is the oldest bit received
- `CNT_W`, 8, width of the match counter
- `clk` input 1: single clock; all state updates on its rising edge
- `rst` input 1: reset, synchronous and active-low (one clock; reset is synchronous and active-low)
- `en` input 1: detection enable; driven by the controller's detector-enable output
- `serial_in` input 1: data bit, sampled on each rising edge while `en`=1
- `clr` input 1: synchronous clear of `match_cnt`
- `w` output 1: match pulse; registered, high for exactly one cycle per match
- `match_cnt` output CNT_W: number of matches, saturating
- `fill` output $clog2(N+1): number of valid bits currently held; debug/status

## Operation
- State: shift register `sr[N-1:0]`, fill counter `fill` (0..N), `w` register, `match_cnt` register.
- `rst`=0 at an edge:
  - `sr`=0, `fill`=0, `w`=0, `match_cnt`=0.
  - Reset overrides every other input.
- `en`=0 at an edge:
  - `fill` is set to 0 and `w` to 0.
  - `sr` holds its value.
  - A partial sequence is discarded.
- `en`=1 at an edge:
  - next `sr` = {sr[N-2:0], serial_in}.
  - next `fill` = min(fill+1, N).
- Match condition:
  - Both values are taken after the update: next `fill`==N and next `sr`==PATTERN.
  - `w` gets this condition on the same edge. Otherwise `w`=0.
- After a match, the fill rule depends on the configuration (see Configuration).
- `match_cnt`:
  - Increments on each edge where the match condition is true.
  - Saturates at 2^CNT_W−1.
  - `clr`=1 has priority over a simultaneous match, so the result is 0.
- `en` falling in the cycle in which `w` is high does not truncate or repeat the pulse.

## Timing
- Latency: `w` is high in the cycle immediately after the edge that sampled the final pattern bit.
- `w` is never high for two consecutive cycles unless two consecutive edges both complete a match. That case is possible only with overlap enabled and a self-overlapping pattern.
- The earliest first match after enable or reset is at the N-th enabled edge.
- `match_cnt` and `w` update on the same edge.
- No combinational path from any input to any output.

## Configuration
- Macro: `PATTERN_DETECT_OVERLAP_EN`.
- Defined (overlapping detection):
  - After a match, `fill` stays at N.
  - The trailing bits of one match may begin the next match.
- Undefined (non-overlapping):
  - On the match edge, next `fill` is forced to 0.
  - The following N enabled bits are all new.

## Structure
- Shared package `pattern_detector_pkg` holds:
  - default `N` and `PATTERN` constants;
  - the `CNT_W` default;
  - the fill-width helper constant.
- One sub-module, `sat_counter`:
  - parameterised width;
  - `inc`/`clr` inputs, with `clr` priority;
  - saturating output.
  - It implements `match_cnt`.
- Shift register, fill logic and match compare stay in `pattern_detector`.

## Test plan
- Basic match: `N`=4, `PATTERN`=1101, `en`=1, `serial_in`=1,1,0,1 → `w`=1 for one cycle after the 4th edge; `match_cnt`=1.
- Overlap: stream 1,1,0,1,1,0,1 →
  - with `PATTERN_DETECT_OVERLAP_EN`: `w` pulses after edges 4 and 7, `match_cnt`=2;
  - without it: one pulse after edge 4, `match_cnt`=1.
- Enable gap: bits 1,1, then `en`=0 for 2 cycles, then `en`=1 with 0,1 → no pulse. Then 1,1,0,1 → pulse; `fill` reads 0 during the gap.
- Reset mid-operation: bits 1,1,0, then `rst`=0 for one edge, then 1 → no pulse; all outputs 0 after the reset edge. A later 1,1,0,1 → pulse, `match_cnt`=1.
- Saturation: 260 non-overlapping matches → `match_cnt`=255 and held.
- Clear collision: `clr`=1 on the same edge as a match → `w`=1, `match_cnt`=0.
